mux2_rr_arbiter: RTL and testbench



---
 rtl/mux2_rr_arbiter.sv | 122 ++++++++++++
 tb/tb_mux2_rr_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux2_rr_arbiter.sv
// Round-robin, burst-limited arbiter feeding a 2:1 mux: two valid/ready producers,
// one registered output beat carrying the mux select and packed data lanes.
module mux2_rr_arbiter #(
  parameter int DATA_WIDTH = 1,
  parameter int MAX_BURST  = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [1:0]              i_valid,
  output logic [1:0]              o_ready,
  input  logic [DATA_WIDTH-1:0]   i_data0,
  input  logic [DATA_WIDTH-1:0]   i_data1,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic                    o_sel,
  output logic [2*DATA_WIDTH-1:0] o_mux_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arbState_e;

  localparam logic [3:0] BurstLimit = 4'(MAX_BURST);
  localparam logic [3:0] BurstSat   = 4'd15;

  arbState_e               state_q, state_d;
  logic                    lastGrant_q, lastGrant_d;
  logic [3:0]              burstCnt_q, burstCnt_d;
  logic                    valid_q, valid_d;
  logic                    sel_q, sel_d;
  logic [2*DATA_WIDTH-1:0] muxData_q, muxData_d;

  logic loadEn;
  logic grantVld;
  logic grantCh;
  logic sameOwner;

  assign loadEn = !valid_q || i_ready;

  // A grant only exists for a requesting channel, so grantVld is itself the transfer.
  always_comb begin
    grantVld = 1'b0;
    grantCh  = 1'b0;
    if (loadEn) begin
      case (i_valid)
        2'b01: begin
          grantVld = 1'b1;
          grantCh  = 1'b0;
        end
        2'b10: begin
          grantVld = 1'b1;
          grantCh  = 1'b1;
        end
        2'b11: begin
          grantVld = 1'b1;
          case (state_q)
            OWN0:    grantCh = (burstCnt_q < BurstLimit) ? 1'b0 : 1'b1;
            OWN1:    grantCh = (burstCnt_q < BurstLimit) ? 1'b1 : 1'b0;
            default: grantCh = ~lastGrant_q;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign o_ready = (i_rst_n && grantVld) ? (grantCh ? 2'b10 : 2'b01) : 2'b00;

  assign sameOwner = grantCh ? (state_q == OWN1) : (state_q == OWN0);

  always_comb begin
    state_d     = state_q;
    lastGrant_d = lastGrant_q;
    burstCnt_d  = burstCnt_q;
    valid_d     = valid_q;
    sel_d       = sel_q;
    muxData_d   = muxData_q;
    if (grantVld) begin
      valid_d     = 1'b1;
      sel_d       = grantCh;
      muxData_d   = grantCh ? {i_data1, {DATA_WIDTH{1'b0}}}
                            : {{DATA_WIDTH{1'b0}}, i_data0};
      lastGrant_d = grantCh;
      state_d     = grantCh ? OWN1 : OWN0;
      if (sameOwner) begin
        burstCnt_d = (burstCnt_q == BurstSat) ? BurstSat : burstCnt_q + 4'd1;
      end else begin
        burstCnt_d = 4'd1;
      end
    end else if (loadEn) begin
      // Nothing to load: drop to IDLE but keep sel/data so the mux input stays quiet.
      valid_d    = 1'b0;
      state_d    = IDLE;
      burstCnt_d = 4'd0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      lastGrant_q <= 1'b1;
      burstCnt_q  <= 4'd0;
      valid_q     <= 1'b0;
      sel_q       <= 1'b0;
      muxData_q   <= '0;
    end else begin
      state_q     <= state_d;
      lastGrant_q <= lastGrant_d;
      burstCnt_q  <= burstCnt_d;
      valid_q     <= valid_d;
      sel_q       <= sel_d;
      muxData_q   <= muxData_d;
    end
  end

  assign o_valid    = valid_q;
  assign o_sel      = sel_q;
  assign o_mux_data = muxData_q;

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Scoreboard bench for mux2_rr_arbiter: a behavioural arbiter model pushes expected
// beats when stimulus is driven; each scenario task pops and compares accepted beats.
module tb_mux2_rr_arbiter;

  localparam int DW   = 1;
  localparam int MAXB = 4;

  logic          i_clk = 1'b0;
  logic          i_rst_n;
  logic [1:0]    i_valid;
  logic [1:0]    o_ready;
  logic [DW-1:0] i_data0;
  logic [DW-1:0] i_data1;
  logic          o_valid;
  logic          i_ready;
  logic          o_sel;
  logic [2*DW-1:0] o_mux_data;

  int compared   = 0;
  int mismatched = 0;

  logic [2*DW:0] sbq[$];
  int   mOwner;
  int   mBurst;
  logic mLast;
  logic mValid;

  mux2_rr_arbiter #(.DATA_WIDTH(DW), .MAX_BURST(MAXB)) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_data0    (i_data0),
    .i_data1    (i_data1),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_sel      (o_sel),
    .o_mux_data (o_mux_data)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic modelReset();
    mValid = 1'b0;
    mOwner = -1;
    mBurst = 0;
    mLast  = 1'b1;
    sbq.delete();
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Drives one cycle of stimulus and advances the model to its post-edge state.
  task automatic driveCycle(input logic [1:0] v, input logic [DW-1:0] d0,
                            input logic [DW-1:0] d1, input logic rdy,
                            output logic [1:0] expReady, output logic expValid,
                            output logic expAccept);
    int g;
    bit loadEn;
    i_valid = v;
    i_data0 = d0;
    i_data1 = d1;
    i_ready = rdy;
    expValid  = mValid;
    expAccept = mValid && rdy;
    loadEn    = !mValid || rdy;
    g = -1;
    if (loadEn) begin
      if (v == 2'b01) g = 0;
      else if (v == 2'b10) g = 1;
      else if (v == 2'b11) begin
        if (mOwner < 0) g = mLast ? 0 : 1;
        else if (mBurst < MAXB) g = mOwner;
        else g = 1 - mOwner;
      end
    end
    expReady = (g == 0) ? 2'b01 : (g == 1) ? 2'b10 : 2'b00;
    if (g >= 0) begin
      sbq.push_back((g == 1) ? {1'b1, d1, {DW{1'b0}}} : {1'b0, {DW{1'b0}}, d0});
      mBurst = (mOwner == g) ? ((mBurst < 15) ? mBurst + 1 : 15) : 1;
      mOwner = g;
      mLast  = (g == 1);
      mValid = 1'b1;
    end else if (loadEn) begin
      mValid = 1'b0;
      mOwner = -1;
      mBurst = 0;
    end
    #1;
  endtask

  task automatic test_reset();
    logic [1:0] eReady;
    logic eValid, eAccept;
    i_rst_n = 1'b0;
    i_valid = 2'b11;
    i_data0 = '1;
    i_data1 = '1;
    i_ready = 1'b1;
    modelReset();
    #12;
    compared++;
    if (o_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_valid: got %b want 0", o_valid); end
    compared++;
    if (o_ready !== 2'b00) begin mismatched++; $display("[TB] FAIL reset_ready: got %b want 00", o_ready); end
    compared++;
    if ({o_sel, o_mux_data} !== '0) begin mismatched++; $display("[TB] FAIL reset_out: got %b_%b want 0_00", o_sel, o_mux_data); end
    @(negedge i_clk);
    i_valid = 2'b00;
    i_rst_n = 1'b1;
    tick();
    driveCycle(2'b11, 1'b1, 1'b1, 1'b1, eReady, eValid, eAccept);
    compared++;
    if (o_ready !== 2'b01) begin mismatched++; $display("[TB] FAIL first_grant: got %b want 01", o_ready); end
    tick();
  endtask

  task automatic test_single_channel();
    logic [1:0] eReady;
    logic eValid, eAccept;
    logic [2*DW:0] expBeat;
    logic [1:0] pat [3];
    pat[0] = 2'b10; pat[1] = 2'b01; pat[2] = 2'b00;
    for (int k = 0; k < 3; k++) begin
      driveCycle(pat[k], 1'b0, 1'b1, 1'b1, eReady, eValid, eAccept);
      compared++;
      if (o_ready !== eReady) begin mismatched++; $display("[TB] FAIL single_ready[%0d]: got %b want %b", k, o_ready, eReady); end
      if (k == 1) begin
        compared++;
        if ({o_valid, o_sel, o_mux_data} !== 4'b1110) begin mismatched++; $display("[TB] FAIL single_ch1_out: got %b%b%b want 1_1_10", o_valid, o_sel, o_mux_data); end
        compared++;
        if (o_mux_data[o_sel] !== 1'b1) begin mismatched++; $display("[TB] FAIL single_mux1: got %b want 1", o_mux_data[o_sel]); end
      end
      if (k == 2) begin
        compared++;
        if (o_sel !== 1'b0 || o_mux_data[o_sel] !== 1'b0) begin mismatched++; $display("[TB] FAIL single_mux0: got sel %b out %b want sel 0 out 0", o_sel, o_mux_data[o_sel]); end
      end
      if (eAccept) begin
        compared++;
        if (sbq.size() == 0) begin mismatched++; $display("[TB] FAIL single_sb[%0d]: got empty want beat", k); end
        else begin
          expBeat = sbq.pop_front();
          if ({o_sel, o_mux_data} !== expBeat) begin mismatched++; $display("[TB] FAIL single_sb[%0d]: got %b want %b", k, {o_sel, o_mux_data}, expBeat); end
        end
      end
      tick();
    end
  endtask

  task automatic test_burst_limit();
    logic [1:0] eReady;
    logic eValid, eAccept;
    logic [2*DW:0] expBeat;
    logic [1:0] want;
    for (int k = -2; k < 12; k++) begin
      if (k == -2) driveCycle(2'b10, 1'b0, 1'b1, 1'b1, eReady, eValid, eAccept);
      else if (k == -1) driveCycle(2'b00, 1'b0, 1'b0, 1'b1, eReady, eValid, eAccept);
      else driveCycle(2'b11, DW'(k % 2), DW'((k + 1) % 2), 1'b1, eReady, eValid, eAccept);
      want = (k < 0) ? eReady : (((k / MAXB) % 2 == 0) ? 2'b01 : 2'b10);
      compared++;
      if (o_ready !== want) begin mismatched++; $display("[TB] FAIL burst_ready[%0d]: got %b want %b", k, o_ready, want); end
      if (eAccept) begin
        compared++;
        if (sbq.size() == 0) begin mismatched++; $display("[TB] FAIL burst_sb[%0d]: got empty want beat", k); end
        else begin
          expBeat = sbq.pop_front();
          if ({o_sel, o_mux_data} !== expBeat) begin mismatched++; $display("[TB] FAIL burst_sb[%0d]: got %b want %b", k, {o_sel, o_mux_data}, expBeat); end
        end
      end
      tick();
    end
  endtask

  task automatic test_stall();
    logic [1:0] eReady;
    logic eValid, eAccept;
    logic [2*DW:0] expBeat;
    for (int k = 0; k < 3; k++) begin
      driveCycle(2'b11, 1'b1, 1'b0, 1'b0, eReady, eValid, eAccept);
      compared++;
      if (o_ready !== 2'b00 || o_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL stall_hs[%0d]: got ready %b valid %b want 00 1", k, o_ready, o_valid); end
      compared++;
      if (sbq.size() == 0 || {o_sel, o_mux_data} !== sbq[0]) begin mismatched++; $display("[TB] FAIL stall_hold[%0d]: got %b want held beat (queue %0d)", k, {o_sel, o_mux_data}, sbq.size()); end
      tick();
    end
    driveCycle(2'b11, 1'b1, 1'b0, 1'b1, eReady, eValid, eAccept);
    compared++;
    if (o_ready !== 2'b10) begin mismatched++; $display("[TB] FAIL stall_release_ready: got %b want 10", o_ready); end
    compared++;
    if (sbq.size() == 0) begin mismatched++; $display("[TB] FAIL stall_release_sb: got empty want beat"); end
    else begin
      expBeat = sbq.pop_front();
      if ({o_sel, o_mux_data} !== expBeat) begin mismatched++; $display("[TB] FAIL stall_release_sb: got %b want %b", {o_sel, o_mux_data}, expBeat); end
    end
    tick();
  endtask

  task automatic test_idle_resume();
    logic [1:0] eReady;
    logic eValid, eAccept;
    logic [2*DW:0] expBeat;
    driveCycle(2'b00, 1'b0, 1'b0, 1'b1, eReady, eValid, eAccept);
    compared++;
    if (o_ready !== 2'b00 || o_valid !== 1'b1 || o_sel !== 1'b1) begin mismatched++; $display("[TB] FAIL idle_held: got ready %b valid %b sel %b want 00 1 1", o_ready, o_valid, o_sel); end
    expBeat = (sbq.size() > 0) ? sbq.pop_front() : '0;
    compared++;
    if ({o_sel, o_mux_data} !== expBeat) begin mismatched++; $display("[TB] FAIL idle_sb: got %b want %b", {o_sel, o_mux_data}, expBeat); end
    tick();
    driveCycle(2'b11, 1'b1, 1'b1, 1'b1, eReady, eValid, eAccept);
    compared++;
    if (o_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL idle_drained: got %b want 0", o_valid); end
    compared++;
    if (o_ready !== 2'b01) begin mismatched++; $display("[TB] FAIL idle_resume_ready: got %b want 01", o_ready); end
    tick();
    driveCycle(2'b00, 1'b0, 1'b0, 1'b1, eReady, eValid, eAccept);
    expBeat = (sbq.size() > 0) ? sbq.pop_front() : '1;
    compared++;
    if ({o_sel, o_mux_data} !== expBeat || o_sel !== 1'b0) begin mismatched++; $display("[TB] FAIL idle_resume_sb: got %b want %b", {o_sel, o_mux_data}, expBeat); end
    tick();
  endtask

  task automatic test_async_reset();
    logic [1:0] eReady;
    logic eValid, eAccept;
    driveCycle(2'b10, 1'b0, 1'b1, 1'b1, eReady, eValid, eAccept);
    compared++;
    if (o_ready !== eReady) begin mismatched++; $display("[TB] FAIL async_grant: got %b want %b", o_ready, eReady); end
    tick();
    driveCycle(2'b10, 1'b0, 1'b1, 1'b0, eReady, eValid, eAccept);
    compared++;
    if (o_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL async_prestall: got %b want 1", o_valid); end
    #1;
    i_rst_n = 1'b0;
    #1;
    compared++;
    if (o_valid !== 1'b0 || o_ready !== 2'b00) begin mismatched++; $display("[TB] FAIL async_drop: got valid %b ready %b want 0 00", o_valid, o_ready); end
    compared++;
    if ({o_sel, o_mux_data} !== '0) begin mismatched++; $display("[TB] FAIL async_out: got %b want 000", {o_sel, o_mux_data}); end
    modelReset();
    @(negedge i_clk);
    i_valid = 2'b00;
    i_rst_n = 1'b1;
    tick();
  endtask

  task automatic test_saturation();
    logic [1:0] eReady;
    logic eValid, eAccept;
    logic [2*DW:0] expBeat;
    for (int k = 0; k < 19; k++) begin
      driveCycle((k < 18) ? 2'b01 : 2'b11, DW'(k % 2), 1'b1, 1'b1, eReady, eValid, eAccept);
      if (k == 18) begin
        compared++;
        if (o_ready !== 2'b10) begin mismatched++; $display("[TB] FAIL sat_switch: got %b want 10", o_ready); end
      end
      if (eAccept) begin
        compared++;
        if (sbq.size() == 0) begin mismatched++; $display("[TB] FAIL sat_sb[%0d]: got empty want beat", k); end
        else begin
          expBeat = sbq.pop_front();
          if ({o_sel, o_mux_data} !== expBeat) begin mismatched++; $display("[TB] FAIL sat_sb[%0d]: got %b want %b", k, {o_sel, o_mux_data}, expBeat); end
        end
      end
      tick();
    end
  endtask

  task automatic test_random();
    logic [1:0] eReady;
    logic eValid, eAccept;
    logic [2*DW:0] expBeat;
    logic [1:0] v;
    logic rdy;
    for (int k = 0; k < 300; k++) begin
      v   = 2'($urandom_range(0, 3));
      rdy = ($urandom_range(0, 3) != 0);
      if (k >= 295) begin v = 2'b00; rdy = 1'b1; end
      driveCycle(v, DW'($urandom_range(0, 1)), DW'($urandom_range(0, 1)), rdy, eReady, eValid, eAccept);
      compared++;
      if (o_ready !== eReady || o_valid !== eValid) begin mismatched++; $display("[TB] FAIL rand_hs[%0d]: got ready %b valid %b want %b %b", k, o_ready, o_valid, eReady, eValid); end
      if (eValid) begin
        compared++;
        if (sbq.size() == 0) begin mismatched++; $display("[TB] FAIL rand_sb[%0d]: got empty want beat", k); end
        else begin
          expBeat = eAccept ? sbq.pop_front() : sbq[0];
          if ({o_sel, o_mux_data} !== expBeat) begin mismatched++; $display("[TB] FAIL rand_sb[%0d]: got %b want %b", k, {o_sel, o_mux_data}, expBeat); end
        end
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_single_channel();
    test_burst_limit();
    test_stall();
    test_idle_resume();
    test_async_reset();
    test_saturation();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
